// File: rtl/sysarr_fifo_feeder.sv
// -----------------------------------------------------------------------------
// sysarr_fifo_feeder
//
// Purpose:
//    Write-side controller for the bank of N per-row systolic-array input
//    FIFOs. A tile arrives as N column-vector beats on a valid/ready stream;
//    each beat is written into all N row FIFOs at once. When the whole tile is
//    resident and the array signals ready, the FIFOs are popped with a diagonal
//    skew so that row i starts i cycles after row 0.
//
// Ports:
//    clk             in   system clock
//    RST             in   synchronous active-high reset
//    in_valid        in   tile beat valid
//    in_ready        out  feeder can accept a beat (LOAD state)
//    in_data         in   N*DW column vector, slice [i*DW +: DW] is row i
//    arr_ready       in   array can start consuming a tile (sampled in WAIT)
//    fifo_load       out  per-row FIFO load strobe
//    fifo_load_vals  out  per-row load data (passthrough of in_data)
//    fifo_shift      out  per-row FIFO pop strobe
//    row_valid       out  row-i FIFO head is a valid operand this cycle
//    busy            out  high unless idle in LOAD with no beats taken
//    tile_done       out  one-cycle pulse after the last pop of a tile
// -----------------------------------------------------------------------------

package sys_arr_pkg;
   parameter int N  = 4;
   parameter int DW = 16;
endpackage

module sysarr_fifo_feeder #(
   parameter int N  = sys_arr_pkg::N,
   parameter int DW = sys_arr_pkg::DW
) (
   input  logic            clk,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            arr_ready,
   output logic [N-1:0]    fifo_load,
   output logic [N*DW-1:0] fifo_load_vals,
   output logic [N-1:0]    fifo_shift,
   output logic [N-1:0]    row_valid,
   output logic            busy,
   output logic            tile_done
);

   // beat counter must hold 0..N, drain counter 0..2N-2
   localparam int BW = $clog2(N + 1);
   localparam int CW = (N > 1) ? $clog2(2 * N - 1) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
   localparam logic [CW-1:0] LAST_CYC  = CW'(2 * N - 2);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   logic [BW-1:0]   r_beat_cnt;
   logic [CW-1:0]   r_cyc_cnt;
   logic            r_tile_done;

   logic            w_accept;
   logic [N-1:0]    w_shift;

   // Beat handshake: ready only in LOAD, so accept is valid qualified by state.
   always_comb begin
      w_accept = 1'b0;
      if (r_state == ST_LOAD) begin
         w_accept = in_valid;
      end else begin
         w_accept = 1'b0;
      end
   end

   // Diagonal pop window: row i pops on drain cycles i .. i+N-1.
   always_comb begin
      w_shift = {N{1'b0}};
      if (r_state == ST_DRAIN) begin
         for (int i = 0; i < N; i++) begin
            w_shift[i] = (int'(r_cyc_cnt) >= i) && (int'(r_cyc_cnt) <= i + N - 1);
         end
      end else begin
         w_shift = {N{1'b0}};
      end
   end

   // Control FSM with beat/drain counters and the registered tile_done pulse.
   always_ff @(posedge clk) begin
      if (RST) begin
         r_state     <= ST_LOAD;
         r_beat_cnt  <= BW'(1'b0);
         r_cyc_cnt   <= CW'(1'b0);
         r_tile_done <= 1'b0;
      end else begin
         r_tile_done <= 1'b0;
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_beat_cnt <= BW'(1'b0);
                     r_state    <= ST_WAIT;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BW'(1'b1);
                  end
               end else begin
                  r_beat_cnt <= r_beat_cnt;
               end
            end
            ST_WAIT: begin
               if (arr_ready) begin
                  r_cyc_cnt <= CW'(1'b0);
                  r_state   <= ST_DRAIN;
               end else begin
                  r_state   <= ST_WAIT;
               end
            end
            ST_DRAIN: begin
               // arr_ready is deliberately ignored here: a drain never stalls
               if (r_cyc_cnt == LAST_CYC) begin
                  r_cyc_cnt   <= CW'(1'b0);
                  r_state     <= ST_LOAD;
                  r_tile_done <= 1'b1;
               end else begin
                  r_cyc_cnt   <= r_cyc_cnt + CW'(1'b1);
               end
            end
            default: begin
               r_state    <= ST_LOAD;
               r_beat_cnt <= BW'(1'b0);
               r_cyc_cnt  <= CW'(1'b0);
            end
         endcase
      end
   end

   // Output decode; loads and shifts are state-exclusive so never overlap.
   always_comb begin
      in_ready       = (r_state == ST_LOAD);
      fifo_load      = {N{w_accept}};
      fifo_load_vals = in_data;
      fifo_shift     = w_shift;
      row_valid      = w_shift;
      busy           = !((r_state == ST_LOAD) && (r_beat_cnt == BW'(1'b0)));
      tile_done      = r_tile_done;
   end

endmodule

// File: tb/tb_sysarr_fifo_feeder.sv
module tb_sysarr_fifo_feeder;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk;
   logic            RST;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_data;
   logic            arr_ready;
   logic [N-1:0]    fifo_load;
   logic [N*DW-1:0] fifo_load_vals;
   logic [N-1:0]    fifo_shift;
   logic [N-1:0]    row_valid;
   logic            busy;
   logic            tile_done;

   sysarr_fifo_feeder #(.N(N), .DW(DW)) dut (
      .clk            (clk),
      .RST            (RST),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .arr_ready      (arr_ready),
      .fifo_load      (fifo_load),
      .fifo_load_vals (fifo_load_vals),
      .fifo_shift     (fifo_shift),
      .row_valid      (row_valid),
      .busy           (busy),
      .tile_done      (tile_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] data;
      logic        ard;
      logic        rdy;
      logic [3:0]  load;
      logic [3:0]  shift;
      logic        busy;
      logic        done;
      logic [31:0] heads;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cur_row  = 0;

   // reference row FIFOs, filled from the load strobes
   logic [7:0] mem [4][4];
   int         wp [4];
   int         rp [4];

   task automatic add(input logic rst, input logic vld, input logic [31:0] data,
                      input logic ard, input logic rdy, input logic [3:0] load,
                      input logic [3:0] shift, input logic bsy, input logic done,
                      input logic [31:0] heads);
      vec_t v;
      v.rst = rst; v.vld = vld; v.data = data; v.ard = ard;
      v.rdy = rdy; v.load = load; v.shift = shift; v.busy = bsy;
      v.done = done; v.heads = heads;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, cur_row, act, exp);
      end
   endtask

   task automatic add_drain(input logic [31:0] h0, input logic [31:0] h1,
                            input logic [31:0] h2, input logic [31:0] h3,
                            input logic [31:0] h4, input logic [31:0] h5,
                            input logic [31:0] h6);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0001, 1, 0, h0);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0011, 1, 0, h1);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0111, 1, 0, h2);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b1111, 1, 0, h3);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b1110, 1, 0, h4);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b1100, 1, 0, h5);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b1000, 1, 0, h6);
   endtask

   initial begin
      int k_done;
      int pops;

      // idle after reset
      add(0, 0, 32'h0, 0, 1, 4'h0, 4'h0, 0, 0, 32'h0);
      // tile A, back-to-back beats
      add(0, 1, 32'h04030201, 0, 1, 4'hF, 4'h0, 0, 0, 32'h0);
      add(0, 1, 32'h08070605, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h0C0B0A09, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h100F0E0D, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      // WAIT with arr_ready low; stray valid must not load
      for (int i = 0; i < 10; i++) add(0, 1, 32'hDEADBEEF, 0, 0, 4'h0, 4'h0, 1, 0, 32'h0);
      add(0, 0, 32'h0, 1, 0, 4'h0, 4'h0, 1, 0, 32'h0);
      // drain A with arr_ready dropped
      add_drain(32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                32'h080B0E00, 32'h0C0F0000, 32'h10000000);
      // tile B, gapped, first beat in the tile_done cycle
      add(0, 1, 32'h14131211, 0, 1, 4'hF, 4'h0, 0, 1, 32'h0);
      add(0, 0, 32'h0,        0, 1, 4'h0, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h18171615, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 0, 32'h0,        0, 1, 4'h0, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h1C1B1A19, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 0, 32'h0,        0, 1, 4'h0, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h201F1E1D, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'hCAFEF00D, 1, 0, 4'h0, 4'h0, 1, 0, 32'h0);
      // drain B: FIFO pointers have wrapped
      add_drain(32'h00000011, 32'h00001215, 32'h00131619, 32'h14171A1D,
                32'h181B1E00, 32'h1C1F0000, 32'h20000000);
      add(0, 0, 32'h0, 0, 1, 4'h0, 4'h0, 0, 1, 32'h0);
      add(0, 0, 32'h0, 0, 1, 4'h0, 4'h0, 0, 0, 32'h0);
      // tile C, reset asserted at drain cycle 3
      add(0, 1, 32'h24232221, 0, 1, 4'hF, 4'h0, 0, 0, 32'h0);
      add(0, 1, 32'h28272625, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h2C2B2A29, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 1, 32'h302F2E2D, 0, 1, 4'hF, 4'h0, 1, 0, 32'h0);
      add(0, 0, 32'h0, 1, 0, 4'h0, 4'h0, 1, 0, 32'h0);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0001, 1, 0, 32'h00000021);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0011, 1, 0, 32'h00002225);
      add(0, 0, 32'h0, 0, 0, 4'h0, 4'b0111, 1, 0, 32'h00232629);
      add(1, 0, 32'h0, 0, 0, 4'h0, 4'b1111, 1, 0, 32'h24272A2D);
      add(0, 0, 32'h0, 0, 1, 4'h0, 4'h0, 0, 0, 32'h0);
      add(0, 0, 32'h0, 0, 1, 4'h0, 4'h0, 0, 0, 32'h0);

      for (int i = 0; i < 4; i++) begin
         wp[i] = 0;
         rp[i] = 0;
      end

      RST = 1'b1; in_valid = 1'b0; in_data = 32'h0; arr_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      for (int k = 0; k < tbl.size(); k++) begin
         cur_row   = k;
         RST       = tbl[k].rst;
         in_valid  = tbl[k].vld;
         in_data   = tbl[k].data;
         arr_ready = tbl[k].ard;
         #4;
         chk("in_ready",   {31'h0, in_ready},   {31'h0, tbl[k].rdy});
         chk("fifo_load",  {28'h0, fifo_load},  {28'h0, tbl[k].load});
         chk("fifo_shift", {28'h0, fifo_shift}, {28'h0, tbl[k].shift});
         chk("row_valid",  {28'h0, row_valid},  {28'h0, tbl[k].shift});
         chk("busy",       {31'h0, busy},       {31'h0, tbl[k].busy});
         chk("tile_done",  {31'h0, tile_done},  {31'h0, tbl[k].done});
         if (tbl[k].load != 4'h0) chk("load_vals", fifo_load_vals, tbl[k].data);
         for (int i = 0; i < 4; i++) begin
            if (tbl[k].shift[i]) begin
               chk($sformatf("head_row%0d", i), {24'h0, mem[i][rp[i]]},
                   {24'h0, tbl[k].heads[i*8 +: 8]});
               rp[i] = (rp[i] + 1) % 4;
            end
         end
         if (fifo_load == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
               mem[i][wp[i]] = fifo_load_vals[i*8 +: 8];
               wp[i] = (wp[i] + 1) % 4;
            end
         end
         if (tbl[k].rst) begin
            for (int i = 0; i < 4; i++) begin
               wp[i] = 0;
               rp[i] = 0;
            end
         end
         @(posedge clk);
         #1;
      end

      // hand-written: full tile, then measure drain length and pop count
      cur_row = tbl.size();
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1;
         in_data  = 32'h44434241 + 32'(b) * 32'h04040404;
         #4;
         chk("hs_load", {28'h0, fifo_load}, {28'h0, 4'hF});
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      arr_ready = 1'b1;
      k_done = 0;
      pops   = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         arr_ready = 1'b0;
         #4;
         pops += $countones(fifo_shift);
         if (tile_done) begin
            k_done = k;
            break;
         end
      end
      chk("hs_drain_len", 32'(k_done), 32'd8);
      chk("hs_pops",      32'(pops),   32'd16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
